// File: rtl/signed_mag_divider.sv
// Multi-cycle restoring divider: signed 16-bit dividend by signed 8-bit divisor.
// Result truncates toward zero; the remainder takes the dividend's sign.
module signed_mag_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    // Handshake: start is sampled only in IDLE; busy is high from INIT through FIX;
    // done pulses for the single DONE cycle, when the result registers are fresh.
    typedef enum logic [2:0] {IDLE, INIT, CHECK, SHIFT, SUB, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [8:0]  r;
    logic [7:0]  q;
    logic [7:0]  m;
    logic [3:0]  count;
    logic        qs;
    logic        rs;

    logic [15:0] dm_abs;
    logic [7:0]  m_abs;
    logic        load_out;
    logic [7:0]  quot_nxt;
    logic [7:0]  rem_nxt;
    logic        dbz_nxt;
    logic        ovf_nxt;

    always_comb begin
        dm_abs = dividend[15] ? (~dividend + 16'd1) : dividend;
        m_abs  = divisor[7]   ? (~divisor + 8'd1)   : divisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        quot_nxt  = 8'h00;
        rem_nxt   = 8'h00;
        dbz_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = INIT;
            end
            INIT:  state_nxt = CHECK;
            CHECK: begin
                if (m == 8'h00) begin
                    state_nxt = DONE;
                    load_out  = 1'b1;
                    dbz_nxt   = 1'b1;
                end else if (r[7:0] >= m) begin
                    // Unsigned quotient would need more than 8 bits.
                    state_nxt = DONE;
                    load_out  = 1'b1;
                    ovf_nxt   = 1'b1;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: state_nxt = SUB;
            SUB:   state_nxt = (count == 4'd1) ? FIX : SHIFT;
            FIX: begin
                state_nxt = DONE;
                load_out  = 1'b1;
                if ((!qs && q > 8'd127) || (qs && q > 8'd128)) begin
                    ovf_nxt = 1'b1;
                end else begin
                    quot_nxt = qs ? (~q + 8'd1) : q;
                    rem_nxt  = rs ? (~r[7:0] + 8'd1) : r[7:0];
                end
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r     <= 9'h000;
            q     <= 8'h00;
            m     <= 8'h00;
            count <= 4'd0;
            qs    <= 1'b0;
            rs    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    r     <= {1'b0, dm_abs[15:8]};
                    q     <= dm_abs[7:0];
                    m     <= m_abs;
                    qs    <= dividend[15] ^ divisor[7];
                    rs    <= dividend[15];
                    count <= 4'd8;
                end
                SHIFT: {r, q} <= {r[7:0], q, 1'b0};
                SUB: begin
                    if (r >= {1'b0, m}) begin
                        r    <= r - {1'b0, m};
                        q[0] <= 1'b1;
                    end
                    count <= count - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= 8'h00;
            remainder   <= 8'h00;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (load_out) begin
            quotient    <= quot_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
            overflow    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_signed_mag_divider.sv
// Bench for signed_mag_divider: directed and random divides, scoreboarded
// against an integer-arithmetic reference model, plus handshake and reset cases.
module tb_signed_mag_divider;

    localparam int W = 43;  // {done_cycle[19:0], busy_len[4:0], ovf, dbz, quot[7:0], rem[7:0]}

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;
    logic        done;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int busy_run = 0;
    logic [7:0] last_q = 8'h00;
    logic [7:0] last_r = 8'h00;
    logic       last_dbz = 1'b0;
    logic       last_ovf = 1'b0;

    signed_mag_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .overflow(overflow), .busy(busy), .done(done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain signed integer division with truncation.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [17:0] res, output int blen);
        int sa, sb, ua, ub, qq, rr;
        sa = $signed(a);
        sb = $signed(b);
        res = 18'h0;
        if (sb == 0) begin
            res[16] = 1'b1;
            blen = 2;
        end else begin
            ua = (sa < 0) ? -sa : sa;
            ub = (sb < 0) ? -sb : sb;
            if (ua / ub >= 256) begin
                res[17] = 1'b1;
                blen = 2;
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                blen = 19;
                if (qq > 127 || qq < -128) res[17] = 1'b1;
                else res[15:0] = {qq[7:0], rr[7:0]};
            end
        end
    endtask

    // Driver tasks
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, n);
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [7:0] b);
        logic [17:0] res;
        int blen;
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        model(a, b, res, blen);
        exp_q.push_back({20'(cyc + 1 + blen), 5'(blen), res});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic check_hold();
        check("hold_quot", {24'h0, quotient}, {24'h0, last_q});
        check("hold_rem", {24'h0, remainder}, {24'h0, last_r});
        check("hold_dbz", {31'h0, div_by_zero}, {31'h0, last_dbz});
        check("hold_ovf", {31'h0, overflow}, {31'h0, last_ovf});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_quot"}, {24'h0, quotient}, 32'h0);
        check({tag, "_rem"}, {24'h0, remainder}, 32'h0);
        check({tag, "_dbz"}, {31'h0, div_by_zero}, 32'h0);
        check({tag, "_ovf"}, {31'h0, overflow}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", {24'h0, quotient}, {24'h0, e[15:8]});
                    check("remainder", {24'h0, remainder}, {24'h0, e[7:0]});
                    check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e[16]});
                    check("overflow", {31'h0, overflow}, {31'h0, e[17]});
                    check("done_cycle", cyc, {12'h0, e[42:23]});
                    check("busy_len", busy_run, {27'h0, e[22:18]});
                    last_q   = e[15:8];
                    last_r   = e[7:0];
                    last_dbz = e[16];
                    last_ovf = e[17];
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        int c;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = 16'h0;
        divisor  = 8'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic, sign matrix, range edges, errors, flag clearing
        do_op(16'h0064, 8'h07);
        do_op(16'hFF9C, 8'h07);
        do_op(16'h0064, 8'hF9);
        do_op(16'hFF9C, 8'hF9);
        do_op(16'd1000, 8'hF7);
        do_op(16'h4000, 8'h80);
        do_op(16'hC000, 8'h80);
        do_op(16'h8000, 8'h01);
        do_op(16'd5,    8'h00);
        do_op(16'd4000, 8'd10);
        do_op(16'h0064, 8'h07);
        wait_idle();
        repeat (3) @(negedge clk);
        check_hold();

        // start pulsed while busy must be ignored
        do_op(16'd1000, 8'd9);
        repeat (3) @(negedge clk);
        dividend = 16'd5;
        divisor  = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check_hold();

        // start held high: back-to-back ops 21 cycles apart
        wait_idle();
        dividend = 16'h0064;
        divisor  = 8'h07;
        start    = 1'b1;
        c = cyc;
        exp_q.push_back({20'(c + 20), 5'd19, 1'b0, 1'b0, 8'h0E, 8'h02});
        exp_q.push_back({20'(c + 41), 5'd19, 1'b0, 1'b0, 8'h0E, 8'h02});
        repeat (22) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a divide
        do_op(16'd1234, 8'd17);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        check_all_zero("inreset");
        rst_n = 1'b1;
        do_op(16'h0064, 8'h07);

        // Random operands, mostly in the valid quotient range
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 16'($urandom);
            end else begin
                a = 16'($urandom_range(0, 2047));
                if ($urandom_range(0, 1) == 1) a = -a;
            end
            b = 8'($urandom);
            if ($urandom_range(0, 15) == 0) b = 8'h00;
            do_op(a, b);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
